// File: rtl/game_event_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_pkg : shared game-state codes, event kinds and event record
// Rev 1.0
// ---------------------------------------------------------------------------
package game_pkg;

  localparam logic [1:0] GS_MENU    = 2'd0;
  localparam logic [1:0] GS_PLAYING = 2'd1;
  localparam logic [1:0] GS_WON     = 2'd2;
  localparam logic [1:0] GS_LOST    = 2'd3;

  localparam int DEDUP_DEPTH = 8;
  localparam int EVT_ID_W    = 8;

  typedef enum logic [1:0] {
    KIND_SLICE    = 2'd0,
    KIND_MISS     = 2'd1,
    KIND_OBSTACLE = 2'd2,
    KIND_RSVD     = 2'd3
  } event_kind_t;

  typedef struct packed {
    event_kind_t         kind;
    logic [EVT_ID_W-1:0] id;
  } event_t;

endpackage
`default_nettype wire

// File: rtl/game_event_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_event_scheduler_if : detector request bus and consumer event stream
// Rev 1.0
// ---------------------------------------------------------------------------
interface game_event_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 8
);
  logic [1:0]                  game_state_in;
  logic [NUM_REQ-1:0]          req_valid_in;
  logic [NUM_REQ*2-1:0]        req_kind_in;
  logic [NUM_REQ*ID_W-1:0]     req_id_in;
  logic [NUM_REQ-1:0]          req_ready_out;
  logic                        evt_valid_out;
  logic [1:0]                  evt_kind_out;
  logic [ID_W-1:0]             evt_id_out;
  logic                        evt_ready_in;
  logic [$clog2(FIFO_DEPTH):0] count_out;
  logic [7:0]                  drop_count_out;

  modport master (
    output game_state_in, req_valid_in, req_kind_in, req_id_in, evt_ready_in,
    input  req_ready_out, evt_valid_out, evt_kind_out, evt_id_out, count_out, drop_count_out
  );

  modport slave (
    input  game_state_in, req_valid_in, req_kind_in, req_id_in, evt_ready_in,
    output req_ready_out, evt_valid_out, evt_kind_out, evt_id_out, count_out, drop_count_out
  );
endinterface
`default_nettype wire

// File: rtl/game_event_scheduler_event_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// event_fifo : first-word-fall-through buffer with synchronous flush
// Rev 1.0
// ---------------------------------------------------------------------------
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     flush,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         push_data,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         head,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is legal only when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule
`default_nettype wire

// File: rtl/game_event_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_event_scheduler : round-robin event arbiter feeding a FWFT buffer
// Optional SLICE de-duplication history: EVENT_DEDUP_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module game_event_scheduler
  import game_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 8
) (
  input wire logic              clk_in,
  input wire logic              rst_n_in,
  game_event_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int EVT_W = 2 + ID_W;

  logic               playing;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   sel;
  logic               found;
  int                 idx;
  logic [1:0]         sel_kind;
  logic [ID_W-1:0]    sel_id;
  logic               grant;
  logic               is_rsvd;
  logic               dup;
  logic               push;
  logic               drop_inc;
  logic               full;
  logic               empty;
  logic               pop;
  logic               space;
  logic               evt_valid;
  logic [EVT_W-1:0]   head;
  logic [CNT_W-1:0]   count;
  logic [7:0]         drop_count;
  logic [NUM_REQ-1:0] ready;

  assign playing   = (bus.game_state_in == GS_PLAYING);
  assign evt_valid = playing && !empty;
  assign pop       = evt_valid && bus.evt_ready_in;
  assign space     = !full || pop;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid_in[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  assign sel_kind = bus.req_kind_in[int'(sel)*2 +: 2];
  assign sel_id   = bus.req_id_in[int'(sel)*ID_W +: ID_W];
  assign next_ptr = (int'(sel) == NUM_REQ-1) ? '0 : sel + 1'b1;
  assign grant    = rst_n_in && playing && found && space;
  assign is_rsvd  = (event_kind_t'(sel_kind) == KIND_RSVD);
  assign push     = grant && !is_rsvd && !dup;
  assign drop_inc = grant && (is_rsvd || dup);

  // Outside PLAYING every offer is swallowed so detectors never stall
  always_comb begin
    ready = '0;
    if (rst_n_in) begin
      if (!playing)   ready      = '1;
      else if (grant) ready[sel] = 1'b1;
    end
  end

`ifdef EVENT_DEDUP_EN
  logic [ID_W-1:0]        hist [DEDUP_DEPTH];
  logic [DEDUP_DEPTH-1:0] hist_vld;

  always_comb begin
    dup = 1'b0;
    if (event_kind_t'(sel_kind) == KIND_SLICE) begin
      for (int i = 0; i < DEDUP_DEPTH; i++) begin
        if (hist_vld[i] && hist[i] == sel_id) dup = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hist_vld <= '0;
      for (int i = 0; i < DEDUP_DEPTH; i++) hist[i] <= '0;
    end else if (!playing) begin
      hist_vld <= '0;
    end else if (push && event_kind_t'(sel_kind) == KIND_SLICE) begin
      for (int i = DEDUP_DEPTH-1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0]  <= sel_id;
      hist_vld <= {hist_vld[DEDUP_DEPTH-2:0], 1'b1};
    end
  end
`else
  assign dup = 1'b0;
`endif

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .flush     (!playing),
    .push      (push),
    .push_data ({sel_kind, sel_id}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr     <= '0;
      drop_count <= '0;
    end else begin
      if (!playing)   rr_ptr <= '0;
      else if (grant) rr_ptr <= next_ptr;
      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  assign bus.req_ready_out  = ready;
  assign bus.evt_valid_out  = evt_valid;
  assign bus.evt_kind_out   = evt_valid ? head[EVT_W-1 -: 2] : 2'b00;
  assign bus.evt_id_out     = evt_valid ? head[ID_W-1:0] : '0;
  assign bus.count_out      = count;
  assign bus.drop_count_out = drop_count;
endmodule
`default_nettype wire

// File: tb/tb_game_event_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_game_event_scheduler : directed scenarios plus randomized model checking
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_game_event_scheduler;
  import game_pkg::*;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int IW = 8;
  localparam int CW = 3;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  game_event_scheduler_if #(.NUM_REQ(N), .FIFO_DEPTH(D), .ID_W(IW)) bus ();

  game_event_scheduler #(.NUM_REQ(N), .FIFO_DEPTH(D), .ID_W(IW)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  bit   [N-1:0]  r_valid;
  logic [1:0]    r_kind [N];
  logic [IW-1:0] r_id   [N];

  task automatic apply_req();
    for (int i = 0; i < N; i++) begin
      bus.req_valid_in[i]         = r_valid[i];
      bus.req_kind_in[2*i +: 2]   = r_kind[i];
      bus.req_id_in[IW*i +: IW]   = r_id[i];
    end
  endtask

  task automatic do_reset();
    rst_n_in          = 1'b0;
    bus.game_state_in = GS_MENU;
    bus.evt_ready_in  = 1'b0;
    r_valid           = '0;
    for (int i = 0; i < N; i++) begin
      r_kind[i] = 2'd0;
      r_id[i]   = '0;
    end
    apply_req();
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_in          = 1'b0;
    bus.game_state_in = GS_PLAYING;
    bus.evt_ready_in  = 1'b1;
    r_valid           = '1;
    for (int i = 0; i < N; i++) begin
      r_kind[i] = 2'd0;
      r_id[i]   = IW'(i + 1);
    end
    apply_req();
    @(posedge clk_in);
    #1;
    vectors++; if (bus.req_ready_out !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready_out); end
    vectors++; if (bus.evt_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_evt_valid: got %b expected 0", bus.evt_valid_out); end
    vectors++; if (bus.evt_kind_out !== 2'd0 || bus.evt_id_out !== 8'd0) begin miscompares++; $display("FAIL reset_evt_data: got kind %0d id %0d expected 0 0", bus.evt_kind_out, bus.evt_id_out); end
    vectors++; if (bus.count_out !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count_out); end
    vectors++; if (bus.drop_count_out !== 8'd0) begin miscompares++; $display("FAIL reset_drop: got %0d expected 0", bus.drop_count_out); end
  endtask

  task automatic test_single();
    do_reset();
    bus.game_state_in = GS_PLAYING;
    bus.evt_ready_in  = 1'b1;
    r_valid = 4'b0001; r_kind[0] = 2'd0; r_id[0] = 8'd5;
    apply_req();
    @(negedge clk_in);
    vectors++; if (bus.req_ready_out !== 4'b0001) begin miscompares++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready_out); end
    vectors++; if (bus.evt_valid_out !== 1'b0) begin miscompares++; $display("FAIL single_pre_valid: got %b expected 0", bus.evt_valid_out); end
    @(posedge clk_in); #1;
    r_valid = '0; apply_req();
    @(negedge clk_in);
    vectors++; if (bus.evt_valid_out !== 1'b1 || bus.evt_kind_out !== 2'd0 || bus.evt_id_out !== 8'd5) begin miscompares++; $display("FAIL single_evt: got v%b k%0d id%0d expected v1 k0 id5", bus.evt_valid_out, bus.evt_kind_out, bus.evt_id_out); end
    @(posedge clk_in); #1;
    @(negedge clk_in);
    vectors++; if (bus.evt_valid_out !== 1'b0) begin miscompares++; $display("FAIL single_drained: got %b expected 0", bus.evt_valid_out); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.game_state_in = GS_PLAYING;
    bus.evt_ready_in  = 1'b1;
    r_valid = '1;
    for (int i = 0; i < N; i++) begin
      r_kind[i] = 2'(i % 3);
      r_id[i]   = IW'(10 + i);
    end
    apply_req();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      vectors++; if (bus.req_ready_out !== 4'(1 << (c % 4))) begin miscompares++; $display("FAIL rr_grant%0d: got %b expected %b", c, bus.req_ready_out, 4'(1 << (c % 4))); end
      if (c > 0) begin
        vectors++; if (bus.evt_valid_out !== 1'b1 || bus.evt_id_out !== IW'(10 + (c-1) % 4)) begin miscompares++; $display("FAIL rr_order%0d: got v%b id%0d expected v1 id%0d", c, bus.evt_valid_out, bus.evt_id_out, 10 + (c-1) % 4); end
      end
      @(posedge clk_in); #1;
    end
    r_valid = '0; apply_req();
  endtask

  task automatic test_full_stall();
    do_reset();
    bus.game_state_in = GS_PLAYING;
    bus.evt_ready_in  = 1'b0;
    r_valid = 4'b0001; r_kind[0] = 2'd1; r_id[0] = 8'd20;
    apply_req();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      vectors++; if (bus.req_ready_out !== 4'b0001) begin miscompares++; $display("FAIL fill_ready%0d: got %b expected 0001", c, bus.req_ready_out); end
      @(posedge clk_in); #1;
      r_id[0] = r_id[0] + 8'd1; apply_req();
    end
    @(negedge clk_in);
    vectors++; if (bus.count_out !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d expected 4", bus.count_out); end
    vectors++; if (bus.req_ready_out !== 4'b0000) begin miscompares++; $display("FAIL full_stall: got %b expected 0000", bus.req_ready_out); end
    @(posedge clk_in); #1;
    bus.evt_ready_in = 1'b1;
    @(negedge clk_in);
    vectors++; if (bus.req_ready_out !== 4'b0001 || bus.evt_id_out !== 8'd20) begin miscompares++; $display("FAIL full_pushpop: got ready %b id %0d expected 0001 id 20", bus.req_ready_out, bus.evt_id_out); end
    @(posedge clk_in); #1;
    r_valid = '0; apply_req();
    @(negedge clk_in);
    vectors++; if (bus.count_out !== 3'd4 || bus.evt_id_out !== 8'd21) begin miscompares++; $display("FAIL full_after: got count %0d id %0d expected 4 21", bus.count_out, bus.evt_id_out); end
  endtask

  task automatic test_leave_playing();
    do_reset();
    bus.game_state_in = GS_PLAYING;
    bus.evt_ready_in  = 1'b0;
    r_valid = 4'b0001; r_kind[0] = 2'd0; r_id[0] = 8'd30;
    apply_req();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_in); #1;
      r_id[0] = r_id[0] + 8'd1; apply_req();
    end
    bus.game_state_in = GS_LOST;
    r_valid = 4'b0011; r_kind[0] = 2'd0; r_id[0] = 8'd40; r_kind[1] = 2'd3; r_id[1] = 8'd41;
    apply_req();
    @(negedge clk_in);
    vectors++; if (bus.evt_valid_out !== 1'b0) begin miscompares++; $display("FAIL leave_valid: got %b expected 0", bus.evt_valid_out); end
    vectors++; if (bus.req_ready_out !== 4'b1111) begin miscompares++; $display("FAIL leave_ready: got %b expected 1111", bus.req_ready_out); end
    @(posedge clk_in); #1;
    @(negedge clk_in);
    vectors++; if (bus.count_out !== 3'd0 || bus.drop_count_out !== 8'd0) begin miscompares++; $display("FAIL leave_flush: got count %0d drop %0d expected 0 0", bus.count_out, bus.drop_count_out); end
    @(posedge clk_in); #1;
    bus.game_state_in = GS_PLAYING;
    r_kind[0] = 2'd1; r_kind[1] = 2'd1; apply_req();
    @(negedge clk_in);
    vectors++; if (bus.evt_valid_out !== 1'b0) begin miscompares++; $display("FAIL rejoin_valid: got %b expected 0", bus.evt_valid_out); end
    vectors++; if (bus.req_ready_out !== 4'b0001) begin miscompares++; $display("FAIL rejoin_rrptr: got %b expected 0001", bus.req_ready_out); end
    @(posedge clk_in); #1;
    r_valid = '0; apply_req();
  endtask

  task automatic test_dedup();
    int emitted;
    int sent;
    int exp_emit;
    int exp_drop;
    logic [1:0] kinds [3];
    kinds[0] = 2'd0; kinds[1] = 2'd0; kinds[2] = 2'd1;
`ifdef EVENT_DEDUP_EN
    exp_emit = 2; exp_drop = 1;
`else
    exp_emit = 3; exp_drop = 0;
`endif
    do_reset();
    bus.game_state_in = GS_PLAYING;
    bus.evt_ready_in  = 1'b1;
    emitted = 0; sent = 0;
    r_valid = 4'b0001; r_kind[0] = kinds[0]; r_id[0] = 8'd9;
    apply_req();
    for (int c = 0; c < 8; c++) begin
      bit acc;
      @(negedge clk_in);
      if (bus.evt_valid_out === 1'b1) emitted++;
      acc = r_valid[0] && bus.req_ready_out[0];
      @(posedge clk_in); #1;
      if (acc) begin
        sent++;
        if (sent < 3) r_kind[0] = kinds[sent];
        else          r_valid   = '0;
        apply_req();
      end
    end
    vectors++; if (sent !== 3) begin miscompares++; $display("FAIL dedup_accepts: got %0d expected 3", sent); end
    vectors++; if (emitted !== exp_emit) begin miscompares++; $display("FAIL dedup_emitted: got %0d expected %0d", emitted, exp_emit); end
    vectors++; if (bus.drop_count_out !== 8'(exp_drop)) begin miscompares++; $display("FAIL dedup_drop: got %0d expected %0d", bus.drop_count_out, exp_drop); end
    // reserved kind is acknowledged and counted, saturating at 255
    r_valid = 4'b0001; r_kind[0] = 2'd3; r_id[0] = 8'd77; apply_req();
    @(negedge clk_in);
    vectors++; if (bus.req_ready_out !== 4'b0001) begin miscompares++; $display("FAIL rsvd_ack: got %b expected 0001", bus.req_ready_out); end
    repeat (260) @(posedge clk_in);
    #1 r_valid = '0; apply_req();
    @(negedge clk_in);
    vectors++; if (bus.drop_count_out !== 8'd255) begin miscompares++; $display("FAIL drop_saturate: got %0d expected 255", bus.drop_count_out); end
    vectors++; if (bus.evt_valid_out !== 1'b0 || bus.count_out !== 3'd0) begin miscompares++; $display("FAIL rsvd_not_queued: got v%b count %0d expected v0 count 0", bus.evt_valid_out, bus.count_out); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.game_state_in = GS_PLAYING;
    bus.evt_ready_in  = 1'b0;
    r_valid = 4'b0001; r_kind[0] = 2'd2; r_id[0] = 8'd50;
    apply_req();
    @(posedge clk_in); #1;
    r_id[0] = 8'd51; apply_req();
    @(posedge clk_in); #1;
    r_id[0] = 8'd52; apply_req();
    @(negedge clk_in);
    vectors++; if (bus.count_out !== 3'd2 || bus.evt_valid_out !== 1'b1) begin miscompares++; $display("FAIL areset_pre: got count %0d v%b expected 2 v1", bus.count_out, bus.evt_valid_out); end
    #2 rst_n_in = 1'b0;
    #1;
    vectors++; if (bus.evt_valid_out !== 1'b0 || bus.evt_id_out !== 8'd0 || bus.evt_kind_out !== 2'd0) begin miscompares++; $display("FAIL areset_evt: got v%b k%0d id%0d expected all 0", bus.evt_valid_out, bus.evt_kind_out, bus.evt_id_out); end
    vectors++; if (bus.count_out !== 3'd0 || bus.req_ready_out !== 4'b0000) begin miscompares++; $display("FAIL areset_state: got count %0d ready %b expected 0 0000", bus.count_out, bus.req_ready_out); end
    @(posedge clk_in); #1;
    r_valid = '0; apply_req();
    rst_n_in = 1'b1;
    bus.evt_ready_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      vectors++; if (bus.evt_valid_out !== 1'b0) begin miscompares++; $display("FAIL areset_quiet%0d: got %b expected 0", c, bus.evt_valid_out); end
      @(posedge clk_in); #1;
    end
    r_valid = 4'b0001; r_kind[0] = 2'd1; r_id[0] = 8'd60; apply_req();
    @(posedge clk_in); #1;
    r_valid = '0; apply_req();
    @(negedge clk_in);
    vectors++; if (bus.evt_valid_out !== 1'b1 || bus.evt_id_out !== 8'd60) begin miscompares++; $display("FAIL areset_new: got v%b id%0d expected v1 id60", bus.evt_valid_out, bus.evt_id_out); end
  endtask

  task automatic test_random(int cycles);
    event_t        q[$];
    logic [IW-1:0] hist[$];
    int            rr;
    int            drop;
    do_reset();
    rr = 0; drop = 0;
    bus.game_state_in = GS_PLAYING;
    for (int c = 0; c < cycles; c++) begin
      bit           playing;
      bit           exp_valid;
      bit           do_pop;
      int           g;
      logic [N-1:0] exp_ready;
      logic [1:0]   exp_kind;
      logic [IW-1:0] exp_id;

      if ($urandom_range(0, 99) < 3)                                     bus.game_state_in = 2'($urandom_range(0, 3));
      else if (bus.game_state_in != GS_PLAYING && $urandom_range(0, 9) < 3) bus.game_state_in = GS_PLAYING;
      bus.evt_ready_in = ($urandom_range(0, 99) < 60);
      for (int i = 0; i < N; i++) begin
        if (!r_valid[i] && $urandom_range(0, 1) == 1) begin
          r_valid[i] = 1'b1;
          r_kind[i]  = 2'($urandom_range(0, 3));
          r_id[i]    = IW'($urandom_range(0, 15));
        end
      end
      apply_req();

      @(negedge clk_in);
      playing   = (bus.game_state_in == GS_PLAYING);
      exp_valid = playing && q.size() > 0;
      do_pop    = exp_valid && bus.evt_ready_in;
      g = -1;
      if (playing) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (rr + k) % N;
          if (g < 0 && r_valid[i]) g = i;
        end
        if (g >= 0 && !(q.size() < D || do_pop)) g = -1;
      end
      exp_ready = !playing ? '1 : (g >= 0 ? N'(1) << g : '0);
      exp_kind  = exp_valid ? q[0].kind : 2'd0;
      exp_id    = exp_valid ? q[0].id   : '0;

      vectors++; if (bus.req_ready_out !== exp_ready) begin miscompares++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, bus.req_ready_out, exp_ready); end
      vectors++; if (bus.evt_valid_out !== exp_valid) begin miscompares++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, bus.evt_valid_out, exp_valid); end
      vectors++; if (bus.evt_kind_out !== exp_kind || bus.evt_id_out !== exp_id) begin miscompares++; $display("FAIL rnd_head c%0d: got k%0d id%0d expected k%0d id%0d", c, bus.evt_kind_out, bus.evt_id_out, exp_kind, exp_id); end
      vectors++; if (bus.count_out !== CW'(q.size())) begin miscompares++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, bus.count_out, q.size()); end
      vectors++; if (bus.drop_count_out !== 8'(drop)) begin miscompares++; $display("FAIL rnd_drop c%0d: got %0d expected %0d", c, bus.drop_count_out, drop); end

      @(posedge clk_in);
      if (!playing) begin
        q.delete();
        hist.delete();
        rr = 0;
      end else begin
        if (do_pop) void'(q.pop_front());
        if (g >= 0) begin
          bit hit;
          rr  = (g + 1) % N;
          hit = 1'b0;
`ifdef EVENT_DEDUP_EN
          if (r_kind[g] == 2'd0) foreach (hist[j]) if (hist[j] == r_id[g]) hit = 1'b1;
`endif
          if (r_kind[g] == 2'd3 || hit) begin
            if (drop < 255) drop++;
          end else begin
            event_t ev;
            ev.kind = event_kind_t'(r_kind[g]);
            ev.id   = r_id[g];
            q.push_back(ev);
            if (r_kind[g] == 2'd0) begin
              hist.push_front(r_id[g]);
              if (hist.size() > DEDUP_DEPTH) void'(hist.pop_back());
            end
          end
        end
      end
      #1;
      for (int i = 0; i < N; i++) if (exp_ready[i]) r_valid[i] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_leave_playing();
    test_dedup();
    test_async_reset();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected completion within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
